// File: rtl/tbt_pkg.sv
// -----------------------------------------------------------------------------
// tbt_pkg
// Shared definitions for the 2x2 matrix-multiplier stream sequencer:
//   - sequencer state encoding
//   - matrix geometry (words per matrix, operand words per job)
//   - default float word width
//   - small slot-decoding helpers used by the operand packer
// -----------------------------------------------------------------------------
package tbt_pkg;

    localparam int FLOATSIZE_DEFAULT = 32;
    localparam int MAT_WORDS         = 4;
    localparam int OPERAND_WORDS     = 8;
    localparam int CNT_W             = 3;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FILL  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    // True on the slot index of the final operand word of a job.
    function automatic logic is_last_operand(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(OPERAND_WORDS - 1);
    endfunction

    // Slots 0..3 belong to matrix A, slots 4..7 to matrix B.
    function automatic logic is_b_slot(input logic [CNT_W-1:0] cnt);
        return cnt >= CNT_W'(MAT_WORDS);
    endfunction

endpackage

// File: rtl/tbt_result_serializer.sv
// -----------------------------------------------------------------------------
// tbt_result_serializer
// Four-word parallel-load result buffer that streams its contents out one
// word per accepted beat, lowest word first, with last flagging the 4th word.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   load, load_data    capture strobe and packed {W3,W2,W1,W0} result words
//   start              begin streaming from word 0 (one-cycle strobe)
//   out_data/out_valid/out_ready/out_last   registered output stream
//   done               high on the beat that transfers the last word
// -----------------------------------------------------------------------------
module tbt_result_serializer
    import tbt_pkg::*;
#(
    parameter int FLOATSIZE = FLOATSIZE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [MAT_WORDS*FLOATSIZE-1:0] load_data,
    input  logic                           start,
    input  logic                           out_ready,
    output logic [FLOATSIZE-1:0]           out_data,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           done
);

    logic [FLOATSIZE-1:0] res_r [MAT_WORDS];
    logic [1:0]           idx_r;
    logic [FLOATSIZE-1:0] data_r;
    logic                 valid_r;
    logic                 last_r;
    logic                 beat_s;

    assign beat_s    = valid_r && out_ready;
    assign done      = beat_s && last_r;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

    // Result buffer: captured in one shot, held until the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAT_WORDS; i++) begin
                res_r[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < MAT_WORDS; i++) begin
                res_r[i] <= load_data[i*FLOATSIZE +: FLOATSIZE];
            end
        end
    end

    // Output stage: data/last only move on an accepted beat, so they stay
    // stable under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= 2'd0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (start) begin
            idx_r   <= 2'd0;
            data_r  <= res_r[0];
            valid_r <= 1'b1;
            last_r  <= 1'b0;
        end else if (beat_s) begin
            if (last_r) begin
                idx_r   <= 2'd0;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                idx_r   <= idx_r + 2'd1;
                data_r  <= res_r[idx_r + 2'd1];
                last_r  <= (idx_r == 2'(MAT_WORDS - 2));
            end
        end
    end

endmodule

// File: rtl/tbt_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tbt_mult_sequencer
// Stream front/back end for the 2x2 floating-point matrix multiplier.
// Collects 8 operand words (A00,A01,A10,A11,B00,B01,B10,B11), pulses the
// multiplier load, waits for its result, completes the result_ready/ack
// handshake and streams the 4 result words (R00,R01,R10,R11) out.
// One job in flight at a time.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      operand word stream
//   mat_a, mat_b                   packed operands {X11,X10,X01,X00}
//   mult_load                      one-cycle start pulse to the multiplier
//   mult_result, mult_result_ready result bus and its valid flag
//   mult_result_ack                result acknowledge, held until ready drops
//   out_data/out_valid/out_ready/out_last   result word stream
//   busy                           low only while collecting operands
// -----------------------------------------------------------------------------
module tbt_mult_sequencer
    import tbt_pkg::*;
#(
    parameter int FLOATSIZE = FLOATSIZE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FLOATSIZE-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [MAT_WORDS*FLOATSIZE-1:0] mat_a,
    output logic [MAT_WORDS*FLOATSIZE-1:0] mat_b,
    output logic                           mult_load,
    input  logic [MAT_WORDS*FLOATSIZE-1:0] mult_result,
    input  logic                           mult_result_ready,
    output logic                           mult_result_ack,
    output logic [FLOATSIZE-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy
);

    state_t               state_r;
    state_t               next_state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 init_seen_r;

    logic                 in_ready_r;
    logic                 mult_load_r;
    logic                 ack_r;
    logic                 busy_r;
    logic                 in_ready_s;
    logic                 mult_load_s;
    logic                 ack_s;
    logic                 busy_s;

    logic [FLOATSIZE-1:0] a_r [MAT_WORDS];
    logic [FLOATSIZE-1:0] b_r [MAT_WORDS];

    logic                 in_beat_s;
    logic                 capture_s;
    logic                 drain_start_s;
    logic                 drain_done_s;

    // in_ready_r is only ever high in S_FILL; the state term keeps the
    // accept condition self-contained.
    assign in_beat_s     = (state_r == S_FILL) && in_ready_r && in_valid;
    assign capture_s     = (state_r == S_WAIT) && mult_result_ready;
    assign drain_start_s = (state_r == S_ACK) && !mult_result_ready;

    assign in_ready        = in_ready_r;
    assign mult_load       = mult_load_r;
    assign mult_result_ack = ack_r;
    assign busy            = busy_r;

    for (genvar g = 0; g < MAT_WORDS; g++) begin : g_pack
        assign mat_a[g*FLOATSIZE +: FLOATSIZE] = a_r[g];
        assign mat_b[g*FLOATSIZE +: FLOATSIZE] = b_r[g];
    end

    // Next-state logic plus next values of the registered control outputs.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_INIT: begin
                // Hold one full cycle after reset release before accepting.
                if (init_seen_r) begin
                    next_state_s = S_FILL;
                end else begin
                    next_state_s = S_INIT;
                end
            end
            S_FILL: begin
                if (in_beat_s && is_last_operand(cnt_r)) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_FILL;
                end
            end
            S_LOAD: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (capture_s) begin
                    next_state_s = S_ACK;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_ACK: begin
                // Ack only drops once result_ready has been seen low.
                if (drain_start_s) begin
                    next_state_s = S_DRAIN;
                end else begin
                    next_state_s = S_ACK;
                end
            end
            S_DRAIN: begin
                if (drain_done_s) begin
                    next_state_s = S_FILL;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            default: begin
                next_state_s = S_INIT;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        in_ready_s  = (next_state_s == S_FILL);
        mult_load_s = (next_state_s == S_LOAD);
        ack_s       = (next_state_s == S_ACK);
        busy_s      = (next_state_s != S_FILL);
    end

    // State register, control output registers and operand slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_INIT;
            init_seen_r <= 1'b0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b0;
            mult_load_r <= 1'b0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            init_seen_r <= 1'b1;
            in_ready_r  <= in_ready_s;
            mult_load_r <= mult_load_s;
            ack_r       <= ack_s;
            busy_r      <= busy_s;
            if (in_beat_s) begin
                // Wraps 7 -> 0 on the final operand.
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Operand registers: written only by accepted beats, so they stay
    // stable for the whole multiplier computation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAT_WORDS; i++) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
            end
        end else if (in_beat_s) begin
            if (is_b_slot(cnt_r)) begin
                b_r[cnt_r[1:0]] <= in_data;
            end else begin
                a_r[cnt_r[1:0]] <= in_data;
            end
        end
    end

    tbt_result_serializer #(
        .FLOATSIZE (FLOATSIZE)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (capture_s),
        .load_data (mult_result),
        .start     (drain_start_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (drain_done_s)
    );

endmodule

// File: tb/tb_tbt_mult_sequencer.sv
module tb_tbt_mult_sequencer;

    localparam int W = 32;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F5 = 32'h40A00000;
    localparam logic [31:0] F6 = 32'h40C00000;
    localparam logic [31:0] F7 = 32'h40E00000;
    localparam logic [31:0] F8 = 32'h41000000;
    localparam logic [31:0] Z  = 32'h00000000;

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] r;
        int           gap;
        int           stall_word;
        int           stall_cycles;
        int           ack_hold;
        int           lat;
    } job_t;

    logic           clk;
    logic           reset;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] mat_a;
    logic [4*W-1:0] mat_b;
    logic           mult_load;
    logic [4*W-1:0] mult_result;
    logic           mult_result_ready;
    logic           mult_result_ack;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;

    int total = 0;
    int bad   = 0;

    job_t jobs [7];

    tbt_mult_sequencer #(.FLOATSIZE(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mat_a             (mat_a),
        .mat_b             (mat_b),
        .mult_load         (mult_load),
        .mult_result       (mult_result),
        .mult_result_ready (mult_result_ready),
        .mult_result_ack   (mult_result_ack),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net: every wait below is bounded, this only guards
    // against a bench bug.
    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

    function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_mult_load"}, mult_load, 1'b0);
        chk({tag, "_ack"}, mult_result_ack, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mat_a"}, mat_a, 128'h0);
        chk({tag, "_mat_b"}, mat_b, 128'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
    endtask

    // Streams the 8 operand words and checks the load pulse and packing.
    task automatic stream_operands(input job_t j);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("fill_in_ready", in_ready, 1'b1);
        chk("fill_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (j.gap != 0) begin
                in_valid = 1'b0;
                in_data  = 32'h0BADF00D;
                @(negedge clk);
                chk("gap_in_ready", in_ready, 1'b1);
                chk("gap_no_load", mult_load, 1'b0);
            end
            in_data  = (i < 4) ? wsel(j.a, i) : wsel(j.b, i - 4);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("load_pulse", mult_load, 1'b1);
        chk("in_ready_drop", in_ready, 1'b0);
        chk("busy_load", busy, 1'b1);
        chk("mat_a_packed", mat_a, j.a);
        chk("mat_b_packed", mat_b, j.b);
    endtask

    // Full job: operands, stub multiplier handshake, drain with backpressure.
    task automatic run_job(input job_t j);
        int got;
        int stall_left;
        int guard;
        stream_operands(j);

        // Junk on the input side while not filling must be ignored.
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("load_single_cycle", mult_load, 1'b0);
        chk("wait_in_ready", in_ready, 1'b0);
        for (int k = 0; k < j.lat; k++) begin
            @(negedge clk);
            chk("wait_no_ack", mult_result_ack, 1'b0);
            chk("wait_no_out", out_valid, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_mat_a", mat_a, j.a);
        end

        mult_result       = j.r;
        mult_result_ready = 1'b1;
        @(negedge clk);
        chk("ack_rise", mult_result_ack, 1'b1);
        chk("ack_busy", busy, 1'b1);
        for (int h = 0; h < j.ack_hold; h++) begin
            @(negedge clk);
            chk("ack_held", mult_result_ack, 1'b1);
            chk("ack_mat_a", mat_a, j.a);
            chk("ack_mat_b", mat_b, j.b);
            chk("ack_no_out", out_valid, 1'b0);
        end

        mult_result_ready = 1'b0;
        mult_result       = {4{32'h5A5A5A5A}};
        in_valid          = 1'b0;
        out_ready         = 1'b0;
        @(negedge clk);
        chk("ack_drop", mult_result_ack, 1'b0);
        chk("drain_valid_rise", out_valid, 1'b1);
        chk("drain_mat_a", mat_a, j.a);

        got        = 0;
        guard      = 0;
        stall_left = j.stall_cycles;
        while (got < 4 && guard < 40) begin
            guard++;
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, wsel(j.r, got));
            chk("drain_last", out_last, (got == 3) ? 1'b1 : 1'b0);
            chk("drain_busy", busy, 1'b1);
            if (got == j.stall_word && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
                got++;
            end
            @(negedge clk);
        end
        chk("drain_count", got, 4);
        chk("drain_end_valid", out_valid, 1'b0);
        chk("drain_end_in_ready", in_ready, 1'b1);
        chk("drain_end_busy", busy, 1'b0);
    endtask

    initial begin
        reset             = 1'b0;
        in_data           = '0;
        in_valid          = 1'b0;
        mult_result       = '0;
        mult_result_ready = 1'b0;
        out_ready         = 1'b0;

        // identity * B, then variations on handshake corner cases
        jobs[0] = '{a: pack4(F1, Z, Z, F1), b: pack4(F1, F2, F3, F4), r: pack4(F1, F2, F3, F4),
                    gap: 0, stall_word: -1, stall_cycles: 0, ack_hold: 0, lat: 2};
        jobs[1] = '{a: pack4(F1, Z, Z, F1), b: pack4(F1, F2, F3, F4), r: pack4(F1, F2, F3, F4),
                    gap: 1, stall_word: -1, stall_cycles: 0, ack_hold: 0, lat: 1};
        jobs[2] = '{a: pack4(F1, Z, Z, F1), b: pack4(F1, F2, F3, F4), r: pack4(F1, F2, F3, F4),
                    gap: 0, stall_word: 1, stall_cycles: 5, ack_hold: 0, lat: 3};
        jobs[3] = '{a: pack4(F1, Z, Z, F1), b: pack4(F1, F2, F3, F4), r: pack4(F1, F2, F3, F4),
                    gap: 0, stall_word: -1, stall_cycles: 0, ack_hold: 3, lat: 4};
        jobs[4] = '{a: pack4(F1, Z, Z, F1), b: pack4(F5, F6, F7, F8), r: pack4(F5, F6, F7, F8),
                    gap: 0, stall_word: -1, stall_cycles: 0, ack_hold: 1, lat: 0};
        jobs[5] = '{a: pack4(F1, Z, Z, F1), b: pack4(F1, F2, F3, F4), r: pack4(F1, F2, F3, F4),
                    gap: 0, stall_word: 3, stall_cycles: 2, ack_hold: 0, lat: 2};
        // 2*I * [1,2,3,4] = [2,4,6,8]
        jobs[6] = '{a: pack4(F2, Z, Z, F2), b: pack4(F1, F2, F3, F4), r: pack4(F2, F4, F6, F8),
                    gap: 0, stall_word: -1, stall_cycles: 0, ack_hold: 2, lat: 1};

        // Reset state and the one-cycle INIT after release.
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("init_in_ready", in_ready, 1'b0);
        chk("init_busy", busy, 1'b1);
        @(negedge clk);
        chk("init_done_in_ready", in_ready, 1'b1);
        chk("init_done_busy", busy, 1'b0);

        // Table-driven jobs; jobs 4 and 5 run back to back with different B.
        for (int n = 0; n < 7; n++) begin
            run_job(jobs[n]);
        end

        // Reset in the middle of S_WAIT aborts the job.
        stream_operands(jobs[0]);
        chk("mat_a_identity", mat_a, 128'h3F800000_00000000_00000000_3F800000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("midwait_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel1_in_ready", in_ready, 1'b0);
        chk("rel1_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("rel2_in_ready", in_ready, 1'b1);
        chk("rel2_out_valid", out_valid, 1'b0);
        chk("rel2_busy", busy, 1'b0);
        run_job(jobs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tbt_mult_sequencer.md
Name: tbt_mult_sequencer

Overview:
Stream front/back end for the 2x2 floating-point matrix multiplier (tbt_mult_async).
- Input side: accepts 8 serial FLOATSIZE words over a valid/ready stream and packs them into the multiplier's A and B buses.
- Control: issues a single-cycle load, waits for result_ready, captures the result, then completes the result_ack handshake.
- Output side: streams the 4 result words out over a valid/ready/last stream.
- Sits between the system data path and the multiplier; at most one matrix job is in flight.

Parameters:
FLOATSIZE, 32, width of one float word; the packed buses are 4*FLOATSIZE.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_data  in  FLOATSIZE  operand word; row-major order A00,A01,A10,A11,B00,B01,B10,B11
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts a word this cycle
mat_a  out  4*FLOATSIZE  {A11,A10,A01,A00}, A00 in bits [FLOATSIZE-1:0]; to multiplier A
mat_b  out  4*FLOATSIZE  {B11,B10,B01,B00}; to multiplier B
mult_load  out  1  start pulse to multiplier load
mult_result  in  4*FLOATSIZE  {R11,R10,R01,R00} from multiplier
mult_result_ready  in  1  multiplier result valid
mult_result_ack  out  1  acknowledge to multiplier
out_data  out  FLOATSIZE  result word; order R00,R01,R10,R11
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  high with R11
busy  out  1  high in every state except S_FILL

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_INIT; cnt=0.
  - in_ready, mult_load, mult_result_ack, out_valid, out_last and busy are all 0.
  - mat_a, mat_b and the result buffer are all 0.
  - All outputs are registered.
- S_INIT: lasts one cycle, then goes to S_FILL. busy=1.
- S_FILL: in_ready=1.
  - Each beat (in_valid && in_ready) writes slot cnt: cnt 0-3 go to mat_a, cnt 4-7 go to mat_b. Then cnt++.
  - Gaps in in_valid are allowed; cnt holds across them.
  - On the beat with cnt==7: cnt<=0, state<=S_LOAD, and in_ready drops in the next cycle. No 9th word is accepted.
- S_LOAD: mult_load=1 for exactly one cycle, then S_WAIT.
- S_WAIT: hold until mult_result_ready=1.
  - Then capture mult_result into the 4-word result buffer and go to S_ACK.
  - mult_result_ready is ignored in every other state.
- S_ACK: mult_result_ack=1 and held.
  - When mult_result_ready is sampled 0, drop ack in the same transition and go to S_DRAIN.
  - Ack is never dropped while result_ready is still high.
- S_DRAIN: out_valid=1; out_data=res[cnt]; out_last=(cnt==3).
  - On a beat (out_valid && out_ready): cnt++.
  - On the last beat: cnt<=0, state<=S_FILL, out_valid drops in the next cycle.
  - While out_valid && !out_ready, out_data and out_last stay stable.
- Operand stability: mat_a and mat_b are written only in S_FILL. They hold stable from the first cycle of S_LOAD through the exit from S_ACK, because the multiplier samples them throughout its computation.
- Boundary conditions:
  - in_valid outside S_FILL is ignored and nothing is consumed.
  - out_ready is ignored when out_valid=0.
  - Reset in any state aborts the job; no partial output is emitted afterwards.
  - Throughput: one job per 8 input beats + multiplier latency + ack + 4 output beats. No overlap between jobs.
- Latency:
  - mult_load rises in the cycle after the 8th input beat.
  - out_valid rises no earlier than 2 cycles after mult_result_ready rises.

Decomposition:
- Shared package tbt_pkg holds:
  - state encoding S_INIT, S_FILL, S_LOAD, S_WAIT, S_ACK, S_DRAIN;
  - MAT_WORDS=4 and OPERAND_WORDS=8;
  - the FLOATSIZE default.
- Sub-module tbt_result_serializer: 4-word parallel-load buffer with valid/ready/last output. Load is strobed on capture, start is strobed on entry to S_DRAIN, and it returns done on the last beat.

Test Plan:
- Identity times B. Stream A=[1.0,0,0,1.0] (0x3F800000,0,0,0x3F800000) and B=[1.0,2.0,3.0,4.0] (0x3F800000,0x40000000,0x40400000,0x40800000) into the real multiplier. Required: out words 0x3F800000, 0x40000000, 0x40400000, 0x40800000, with out_last only on the 4th.
- Input gaps. Same operands with in_valid low on alternate cycles. Required:
  - mat_a={0x3F800000,0,0,0x3F800000} is packed exactly;
  - mult_load is a single-cycle pulse exactly 1 cycle after the 8th beat;
  - in_ready=0 from the next cycle.
- Output backpressure. Hold out_ready=0 for 5 cycles on word 2. Required: out_data stays 0x40000000 and out_valid stays 1 throughout; no word is lost or duplicated.
- Ack handshake with a stub multiplier that holds result_ready for 3 cycles after ack. Required:
  - mult_result_ack stays high for all 3 cycles and drops only after result_ready=0;
  - mat_a and mat_b stay unchanged during WAIT and ACK.
- Reset mid-S_WAIT. Assert reset=0 for 2 cycles. Required:
  - all outputs go to 0 immediately;
  - in_ready=1 exactly 2 clocks after release;
  - a fresh 8-word job then completes correctly.
- Back-to-back jobs: 2 consecutive jobs with different B. Required: two correct 4-word results in order, and busy=0 only while in S_FILL.
